// File: rtl/picomips_fetch.sv
// picoMips program counter and fetch sequencer: drives the synchronous program memory,
// qualifies returned words, and executes HEI waits against a synchronised, debounced SW8.
module picomips_fetch #(
  parameter logic [5:0]  HeiOp       = 6'd1,
  parameter logic [4:0]  LastAddr    = 5'd27,
  parameter int unsigned DebounceLen = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       sw8_i,
  input  logic [9:0] instruction_i,
  output logic [4:0] addr_o,
  output logic       instr_valid_o,
  output logic [4:0] instr_addr_o,
  output logic       waiting_o,
  output logic       sw8_db_o
);

  typedef enum logic [1:0] {StFill, StRun, StWait} state_e;

  localparam logic [15:0] CntMax = 16'(DebounceLen - 1);

  state_e      state_q, state_d;
  logic [4:0]  addr_q, addr_d;
  logic [4:0]  iaddr_q, iaddr_d;
  logic        target_q, target_d;
  logic        s1_q, s2_q;
  logic        db_q, db_d;
  logic [15:0] cnt_q, cnt_d;

  logic        is_hei;
  logic        advance;
  logic [4:0]  next_addr;
  logic        unused_imm;

  assign is_hei     = (instruction_i[9:4] == HeiOp);
  assign next_addr  = (addr_q == LastAddr) ? 5'd0 : addr_q + 5'd1;
  assign unused_imm = ^instruction_i[3:1];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StFill;
      addr_q   <= '0;
      iaddr_q  <= '0;
      target_q <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      db_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      iaddr_q  <= iaddr_d;
      target_q <= target_d;
      s1_q     <= sw8_i;
      s2_q     <= s1_q;
      db_q     <= db_d;
      cnt_q    <= cnt_d;
    end
  end

  // Any disagreement between s2 and the debounced level must persist DebounceLen cycles.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (s2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      db_d  = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    advance  = 1'b0;
    unique case (state_q)
      StFill: begin
        advance = 1'b1;
        state_d = StRun;
      end
      StRun: begin
        if (!is_hei || (db_q != instruction_i[0])) begin
          advance = 1'b1;
        end else begin
          target_d = instruction_i[0];
          state_d  = StWait;
        end
      end
      StWait: begin
        if (db_q != target_q) begin
          advance = 1'b1;
          state_d = StRun;
        end
      end
      default: state_d = StFill;
    endcase
    addr_d  = advance ? next_addr : addr_q;
    iaddr_d = advance ? addr_q : iaddr_q;
  end

  always_comb begin
    instr_valid_o = (state_q == StRun) && !is_hei;
    waiting_o     = (state_q == StWait);
  end

  assign addr_o       = addr_q;
  assign instr_addr_o = iaddr_q;
  assign sw8_db_o     = db_q;

endmodule

// File: tb/tb_picomips_fetch.sv
// Self-checking bench for picomips_fetch: synchronous memory model plus an address scoreboard
// of expected valid instructions, popped whenever the DUT asserts instr_valid_o.
module tb_picomips_fetch;

  localparam logic [5:0] HeiOp = 6'd1;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       sw8_i = 1'b0;
  logic [9:0] instr = '0;
  logic [4:0] addr;
  logic       valid;
  logic [4:0] ia;
  logic       waiting;
  logic       db;

  logic [9:0] mem [32];
  int         total = 0;
  int         bad = 0;
  int         exp_q[$];

  picomips_fetch #(
    .HeiOp      (HeiOp),
    .LastAddr   (5'd27),
    .DebounceLen(4)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .sw8_i        (sw8_i),
    .instruction_i(instr),
    .addr_o       (addr),
    .instr_valid_o(valid),
    .instr_addr_o (ia),
    .waiting_o    (waiting),
    .sw8_db_o     (db)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) instr <= mem[addr];

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle and score any valid instruction against the next expected address.
  task automatic tick();
    int e;
    @(negedge clk_i);
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected", 32'(ia), 32'hffff_ffff);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_addr", 32'(ia), 32'(e));
      end
    end
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_q.push_back(i);
  endtask

  task automatic fill_normal();
    for (int i = 0; i < 32; i++) mem[i] = {6'(i + 2), 4'(i)};
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    exp_q.delete();
    repeat (3) tick();
  endtask

  task automatic wait_release(input int want);
    int n;
    n = 0;
    while (waiting === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check_eq("rel_lat", 32'(n), 32'(want));
  endtask

  int inval;
  int wt;

  initial begin
    // Reset then free-run across the wrap.
    fill_normal();
    do_reset();
    check_eq("rst_addr", 32'(addr), 0);
    check_eq("rst_valid", 32'(valid), 0);
    check_eq("rst_wait", 32'(waiting), 0);
    check_eq("rst_db", 32'(db), 0);
    reset_i = 1'b0;
    push_range(0, 27);
    push_range(0, 4);
    for (int k = 1; k <= 33; k++) begin
      tick();
      check_eq("run_addr", 32'(addr), 32'(k % 28));
      check_eq("run_valid", 32'(valid), 1);
    end
    check_eq("sb_left", 32'(exp_q.size()), 0);

    // Blocked HEI 0 at address 0.
    mem[0] = {HeiOp, 4'd0};
    sw8_i = 1'b0;
    do_reset();
    reset_i = 1'b0;
    push_range(1, 1);
    tick();
    check_eq("hei_v0", 32'(valid), 0);
    check_eq("hei_w0", 32'(waiting), 0);
    repeat (8) begin
      tick();
      check_eq("blk_wait", 32'(waiting), 1);
      check_eq("blk_addr", 32'(addr), 1);
    end
    sw8_i = 1'b1;
    repeat (5) tick();
    check_eq("db_e5", 32'(db), 0);
    tick();
    check_eq("db_e6", 32'(db), 1);
    check_eq("blk_wait6", 32'(waiting), 1);
    tick();
    check_eq("rel_wait", 32'(waiting), 0);
    check_eq("rel_valid", 32'(valid), 1);
    check_eq("rel_ia", 32'(ia), 1);
    check_eq("rel_addr", 32'(addr), 2);
    check_eq("sb_left", 32'(exp_q.size()), 0);

    // HEI 1 at 7 with Sw8Db already 1: must block until SW8 drops.
    fill_normal();
    mem[7] = {HeiOp, 4'd1};
    sw8_i = 1'b1;
    do_reset();
    reset_i = 1'b0;
    push_range(0, 6);
    repeat (8) tick();
    check_eq("h1_ia", 32'(ia), 7);
    check_eq("h1_valid", 32'(valid), 0);
    check_eq("h1_db", 32'(db), 1);
    tick();
    check_eq("h1_wait", 32'(waiting), 1);
    check_eq("h1_addr", 32'(addr), 8);
    repeat (4) tick();
    check_eq("h1_hold", 32'(waiting), 1);
    push_range(8, 8);
    sw8_i = 1'b0;
    wait_release(7);
    check_eq("h1_rel_valid", 32'(valid), 1);
    check_eq("h1_rel_ia", 32'(ia), 8);
    check_eq("h1_rel_addr", 32'(addr), 9);
    check_eq("sb_left", 32'(exp_q.size()), 0);

    // HEI 1 at 7 already satisfied: one bubble, no wait.
    sw8_i = 1'b0;
    do_reset();
    reset_i = 1'b0;
    push_range(0, 6);
    push_range(8, 9);
    inval = 0;
    wt = 0;
    repeat (10) begin
      tick();
      if (valid !== 1'b1) inval++;
      if (waiting !== 1'b0) wt++;
    end
    check_eq("sat_bubbles", 32'(inval), 1);
    check_eq("sat_wait", 32'(wt), 0);
    check_eq("sat_ia", 32'(ia), 9);
    check_eq("sat_addr", 32'(addr), 10);
    check_eq("sb_left", 32'(exp_q.size()), 0);

    // Glitch rejection while waiting on HEI 0, then a long pulse releases.
    fill_normal();
    mem[0] = {HeiOp, 4'd0};
    do_reset();
    reset_i = 1'b0;
    repeat (2) tick();
    check_eq("gl_wait", 32'(waiting), 1);
    sw8_i = 1'b1;
    repeat (2) tick();
    sw8_i = 1'b0;
    repeat (8) tick();
    check_eq("gl_db", 32'(db), 0);
    check_eq("gl_hold", 32'(waiting), 1);
    check_eq("gl_addr", 32'(addr), 1);
    push_range(1, 1);
    sw8_i = 1'b1;
    repeat (6) tick();
    check_eq("gl6_db", 32'(db), 1);
    sw8_i = 1'b0;
    tick();
    check_eq("gl6_wait", 32'(waiting), 0);
    check_eq("gl6_valid", 32'(valid), 1);
    check_eq("gl6_ia", 32'(ia), 1);
    check_eq("sb_left", 32'(exp_q.size()), 0);

    // Reset while waiting and mid-debounce.
    do_reset();
    reset_i = 1'b0;
    repeat (2) tick();
    check_eq("rw_wait", 32'(waiting), 1);
    sw8_i = 1'b1;
    repeat (3) tick();
    reset_i = 1'b1;
    sw8_i = 1'b0;
    tick();
    check_eq("rw_addr", 32'(addr), 0);
    check_eq("rw_wait0", 32'(waiting), 0);
    check_eq("rw_db", 32'(db), 0);
    check_eq("rw_valid", 32'(valid), 0);
    mem[0] = {6'd2, 4'd0};
    tick();
    reset_i = 1'b0;
    push_range(0, 2);
    repeat (3) tick();
    check_eq("rw_ia", 32'(ia), 2);
    check_eq("rw_addr3", 32'(addr), 3);
    check_eq("sb_left", 32'(exp_q.size()), 0);

    // HEI 0 at the last address.
    fill_normal();
    mem[27] = {HeiOp, 4'd0};
    do_reset();
    reset_i = 1'b0;
    push_range(0, 26);
    repeat (28) tick();
    check_eq("la_ia", 32'(ia), 27);
    check_eq("la_valid", 32'(valid), 0);
    check_eq("la_addr", 32'(addr), 0);
    repeat (4) tick();
    check_eq("la_wait", 32'(waiting), 1);
    check_eq("la_hold", 32'(addr), 0);
    push_range(0, 0);
    sw8_i = 1'b1;
    wait_release(7);
    check_eq("la_rel_valid", 32'(valid), 1);
    check_eq("la_rel_ia", 32'(ia), 0);
    check_eq("la_rel_addr", 32'(addr), 1);
    check_eq("sb_left", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
